seq_shift_add_mult: RTL
=======================

# seq_shift_add_mult

Parametrised sequential shift-and-add multiplier with a start/done handshake and a runtime signed/unsigned mode. It multiplies an M-bit operand A by an N-bit operand B over N iteration cycles. It holds the M+N-bit product C until the next accepted start. It is the general-purpose successor to the fixed 4x4 multiplier and sits in datapaths where area matters more than throughput.

## Interface
Parameters:
- M, default 4: width of operand A (M >= 2).
- N, default 4: width of operand B and iteration count (N >= 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising edge.
- mode  input  1  0 = unsigned, 1 = two's-complement signed; latched with start.
- A  input  M  multiplicand; latched with start.
- B  input  N  multiplier; latched with start.
- busy  output  1  high while an operation is in progress (LOAD/RUN).
- done  output  1  one-cycle pulse when C becomes valid.
- C  output  M+N  product; held stable until the next accepted start.

## Operation
- States: IDLE, RUN, FIN.
  - IDLE -> RUN on start.
  - RUN -> FIN after the N-th iteration.
  - FIN -> RUN on start; otherwise FIN -> IDLE.
- Start acceptance:
  - start is accepted in IDLE or FIN.
  - start in RUN is ignored, with no effect on the operation in flight.
- Load (on the accepted start edge):
  - Latch mode and the sign of each operand (A[M-1], B[N-1]; treated as 0 when mode=0).
  - Load |A| into the M-bit multiplicand register and |B| into the N-bit multiplier register.
  - Clear the (M+N)-bit accumulator and set the iteration count to 0.
- |x| rules:
  - Computed in M or N bits.
  - The most negative value -2^(M-1) maps to 2^(M-1), which fits unsigned.
- Each RUN cycle:
  - If the multiplier LSB is 1, add the multiplicand into the accumulator's upper bits, with carry into an M+1-bit sum.
  - Shift {carry, accumulator} right by one, and the multiplier right by one.
  - Increment the count. The N-th cycle moves to FIN.
- FIN entry edge:
  - C <= (signA XOR signB) ? -acc : acc, in M+N bits.
  - done = 1 for exactly that one cycle.
- Width:
  - M+N bits always hold the full product in both modes, so no overflow or saturation logic exists.
  - Unsigned: 0 .. (2^M-1)(2^N-1).
  - Signed: -2^(M+N-2)+… .. 2^(M+N-2).

## Timing
- Reset values: busy=0, done=0, C=0, state=IDLE, all internal registers 0.
- Latency: start sampled at edge k gives busy=1 from k to k+N, and done=1 with C valid after edge k+N+1.
- Total latency is N+1 cycles from start to done.
- Back-to-back:
  - start high while done=1 is accepted.
  - The next done follows N+1 cycles later, giving an initiation interval of N+1.
- C changes only on the FIN-entry edge or on reset.
- Reset mid-operation:
  - Immediate asynchronous clear of all state and outputs.
  - The aborted result is never presented and done does not pulse.
  - The first start after rst deasserts behaves as from IDLE.
- Operand changes on A/B/mode after the start edge have no effect on the operation in flight.

## Structure
- Shared package mult_pkg:
  - State enum (IDLE, RUN, FIN).
  - Default M/N constants.
  - Iteration counter width function clog2(N+1).
- One sub-module, mult_abs_neg, parametrised by width with inputs x and neg and output neg ? -x : x.
  - Instantiated for |A|, for |B|, and for the final product sign fix.

## Test plan
M=N=4 unless stated.
- Unsigned: A=1111, B=1111, mode=0 -> done after 5 cycles, C=8'hE1 (225). Also A=1100, B=0010 -> C=8'h18.
- Signed: mode=1 with the following cases:
  - A=1011, B=0011 (-5*3) -> C=8'hF1 (-15).
  - A=1111, B=1111 (-1*-1) -> C=8'h01.
  - A=1000, B=1000 (-8*-8) -> C=8'h40.
- Zero and identity: A=0000, B=1010 -> C=0. A=1111, B=0001, mode=0 -> C=8'h0F.
- Handshake:
  - start re-pulsed during RUN -> ignored, with the single done at 5 cycles carrying the original product.
  - start while done=1 -> second done exactly 5 cycles later, and C holds the first product in between.
- Reset: assert rst 2 cycles into A=1111, B=1111 -> busy, done and C go to 0 immediately, and no done follows. A new start gives the correct result.
- Parametrised: M=8, N=6, signed: A=8'h80, B=6'h20 (-128*-32) -> C=14'h1000 (4096).

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_M = 4;
  localparam int DEF_N = 4;

  // Counter must reach N itself, so it needs room for values 0..N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/done handshake and operand/product bus of the multiplier.
interface seq_shift_add_mult_if #(
  parameter int M = mult_pkg::DEF_M,
  parameter int N = mult_pkg::DEF_N
);
  logic           start;
  logic           mode;
  logic [M-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [M+N-1:0] C;

  modport master (output start, mode, A, B, input busy, done, C);
  modport slave  (input start, mode, A, B, output busy, done, C);
endinterface

// File: rtl/mult_abs_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module mult_abs_neg #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + 1'b1) : x;
endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: magnitudes are multiplied over N cycles,
// the sign is applied once when the product is published.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N
) (
  input logic              clk,
  input logic              rst,
  seq_shift_add_mult_if.slave bus
);
  localparam int CW = cnt_width(N);

  state_t         state_reg, state_next;
  logic [M-1:0]   mcand_reg;
  logic [N-1:0]   mplier_reg;
  logic [M+N-1:0] acc_reg;
  logic [CW-1:0]  cnt_reg;
  logic           sign_a_reg, sign_b_reg;
  logic [M+N-1:0] c_reg;

  logic           sign_a, sign_b;
  logic [M-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic [M:0]     sum;
  logic [M+N-1:0] prod_fixed;
  logic           accept;
  logic           last;

  assign sign_a = bus.mode & bus.A[M-1];
  assign sign_b = bus.mode & bus.B[N-1];
  assign accept = bus.start && (state_reg != RUN);
  assign last   = (cnt_reg == CW'(N));

  mult_abs_neg #(.W(M)) u_abs_a (.x(bus.A), .neg(sign_a), .y(abs_a));
  mult_abs_neg #(.W(N)) u_abs_b (.x(bus.B), .neg(sign_b), .y(abs_b));
  mult_abs_neg #(.W(M+N)) u_fix (
    .x  (acc_reg),
    .neg(sign_a_reg ^ sign_b_reg),
    .y  (prod_fixed)
  );

  // Carry out of the upper-half add lands in the MSB after the shift.
  assign sum = {1'b0, acc_reg[M+N-1:N]} + {1'b0, (mplier_reg[0] ? mcand_reg : {M{1'b0}})};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last) state_next = FIN;
      FIN:     state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      c_reg      <= '0;
    end else if (accept) begin
      mcand_reg  <= abs_a;
      mplier_reg <= abs_b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sign_a_reg <= sign_a;
      sign_b_reg <= sign_b;
    end else if (state_reg == RUN) begin
      if (!last) begin
        acc_reg    <= {sum, acc_reg[N-1:1]};
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + 1'b1;
      end else begin
        c_reg <= prod_fixed;
      end
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == FIN);
  assign bus.C    = c_reg;

endmodule
